// File: rtl/sched_rewind.sv
// sched_rewind: inverse SHA-256 message-schedule expansion; rewinds a 16-word window STEPS steps
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data load window W[k..k+15] oldest first;
//        out_valid/out_ready/out_data stream W[k-STEPS..k-STEPS+15] oldest first; busy high in RUN/DRAIN.
// Option: SCHED_REWIND_TWO_STEP_EN performs two chained backward steps per RUN cycle.
module sched_rewind #(
  parameter int STEPS = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);
  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;
  localparam logic [5:0] LAST = 6'(STEPS == 0 ? 0 : STEPS - 1);
  state_t      r_state;
  logic [31:0] r_win [16];
  logic [5:0]  r_scnt;
  logic [3:0]  r_wcnt;
  logic        r_in_ready, r_out_valid, r_busy;
  logic [31:0] r_out_data;
  logic [31:0] w_n1;
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  // W[t-16] = W[t] - s1(W[t-2]) - W[t-7] - s0(W[t-15]) with win[15] as W[t]
  assign w_n1 = r_win[15] - s1(r_win[13]) - r_win[8] - s0(r_win[0]);
`ifdef SCHED_REWIND_TWO_STEP_EN
  localparam logic [5:0] LAST2 = 6'(STEPS < 2 ? 0 : STEPS - 2);
  logic [31:0] w_n2;
  // second step sees the window already shifted once, with w_n1 as its oldest word
  assign w_n2 = r_win[14] - s1(r_win[12]) - r_win[7] - s0(w_n1);
`endif
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
      r_scnt      <= '0;
      r_wcnt      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        LOAD: if (in_valid) begin
          r_win[r_wcnt] <= in_data;
          r_wcnt        <= r_wcnt + 4'd1;
          if (r_wcnt == 4'd15) begin
            r_scnt     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (STEPS == 0) begin
              r_state     <= DRAIN;
              r_out_valid <= 1'b1;
              r_out_data  <= r_win[0];
            end else r_state <= RUN;
          end
        end
        RUN: begin
`ifdef SCHED_REWIND_TWO_STEP_EN
          if (r_scnt == LAST) begin
            for (int i = 0; i < 15; i++) r_win[i+1] <= r_win[i];
            r_win[0]    <= w_n1;
            r_scnt      <= r_scnt + 6'd1;
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_out_data  <= w_n1;
          end else begin
            for (int i = 0; i < 14; i++) r_win[i+2] <= r_win[i];
            r_win[1] <= w_n1;
            r_win[0] <= w_n2;
            r_scnt   <= r_scnt + 6'd2;
            if (r_scnt == LAST2) begin
              r_state     <= DRAIN;
              r_out_valid <= 1'b1;
              r_out_data  <= w_n2;
            end
          end
`else
          for (int i = 0; i < 15; i++) r_win[i+1] <= r_win[i];
          r_win[0] <= w_n1;
          r_scnt   <= r_scnt + 6'd1;
          if (r_scnt == LAST) begin
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_out_data  <= w_n1;
          end
`endif
        end
        DRAIN: if (out_ready) begin
          r_wcnt <= r_wcnt + 4'd1;
          if (r_wcnt == 4'd15) begin
            r_state     <= LOAD;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end else r_out_data <= r_win[r_wcnt + 4'd1];
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sched_rewind.sv
// tb_sched_rewind: table-driven scoreboard bench for sched_rewind at STEPS 1, 48, 47, 0
module tb_sched_rewind;
  localparam int ST [4] = '{1, 48, 47, 0};
  typedef struct {int inst; int kind; bit stall; int lat; int bsy;} vec_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  iv, ordy;
  logic [31:0] id [4];
  wire  [3:0]  ir, ov, bsy;
  wire  [31:0] od [4];
  logic [31:0] W [64];
  logic [31:0] q [$];
  vec_t        tv [10];
  int          pass = 0, total = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sched_rewind #(.STEPS(ST[g])) u (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]), .busy(bsy[g])
    );
  end
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] fs0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] fs1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic int exp_lat(input int s);
`ifdef SCHED_REWIND_TWO_STEP_EN
    return (s + 1) / 2 + 1;
`else
    return s + 1;
`endif
  endfunction
  function automatic vec_t mk(input int i, input int k, input bit s);
    vec_t v;
    v.inst = i; v.kind = k; v.stall = s;
    v.lat = exp_lat(ST[i]);
    v.bsy = exp_lat(ST[i]) - 1 + 16;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h want %h", nm, a, e);
    else pass++;
  endtask
  // forward SHA-256 expansion of a message block (0 abc, 1 zero, 2 random)
  task automatic build(input int kind);
    for (int j = 0; j < 16; j++) W[j] = (kind == 2) ? $urandom : 32'h0;
    if (kind == 0) begin W[0] = 32'h61626380; W[15] = 32'h00000018; end
    for (int t = 16; t < 64; t++) W[t] = fs1(W[t-2]) + W[t-7] + fs0(W[t-15]) + W[t-16];
  endtask
  task automatic load(input int i, input int k, input int cnt);
    for (int j = 0; j < cnt; j++) begin
      @(negedge clk);
      iv[i] = 1'b1; id[i] = W[k+j];
      chk("in_ready_load", {31'b0, ir[i]}, 32'd1);
      @(posedge clk);
    end
    #1 iv[i] = 1'b0;
  endtask
  task automatic run_case(input vec_t v);
    int n, got, first, bc;
    bit held, r;
    logic [31:0] hv, e;
    int i;
    i = v.inst;
    build(v.kind);
    for (int j = 0; j < 16; j++) q.push_back(W[j]);
    load(i, ST[i], 16);
    n = 0; got = 0; first = 0; bc = 0; held = 0; hv = '0;
    while (got < 16 && n < 400) begin
      @(negedge clk);
      n++;
      if (bsy[i]) bc++;
      if (ov[i] && first == 0) first = n;
      if (held && ov[i]) chk("stall_hold", od[i], hv);
      held = 0;
      r = v.stall ? (n % 2 == 1) : 1'b1;
      ordy[i] = r;
      if (ov[i]) begin
        chk("in_ready_drain", {31'b0, ir[i]}, 32'd0);
        if (r) begin
          e = q.pop_front();
          chk("data", od[i], e);
          got++;
        end else begin
          held = 1; hv = od[i];
        end
      end
    end
    if (got < 16) begin
      chk("timeout", got, 16);
      q.delete();
    end
    chk("latency", first, v.lat);
    if (!v.stall) chk("busy_cycles", bc, v.bsy);
    @(posedge clk);
    @(negedge clk);
    ordy[i] = 1'b0;
    chk("done_in_ready", {31'b0, ir[i]}, 32'd1);
    chk("done_out_valid", {31'b0, ov[i]}, 32'd0);
    chk("done_busy", {31'b0, bsy[i]}, 32'd0);
  endtask
  task automatic reset_pulse(input int i);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, ir[i]}, 32'd1);
    chk("rst_out_valid", {31'b0, ov[i]}, 32'd0);
    chk("rst_busy", {31'b0, bsy[i]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; iv = '0; ordy = '0;
    for (int j = 0; j < 4; j++) id[j] = '0;
    tv[0] = mk(0, 0, 0); tv[1] = mk(1, 0, 0); tv[2] = mk(2, 0, 0); tv[3] = mk(3, 0, 0);
    tv[4] = mk(1, 1, 0); tv[5] = mk(0, 1, 1); tv[6] = mk(1, 2, 1); tv[7] = mk(2, 2, 0);
    tv[8] = mk(3, 2, 1); tv[9] = mk(0, 2, 0);
    repeat (2) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      chk("reset_in_ready", {31'b0, ir[j]}, 32'd1);
      chk("reset_out_valid", {31'b0, ov[j]}, 32'd0);
      chk("reset_out_data", od[j], 32'd0);
      chk("reset_busy", {31'b0, bsy[j]}, 32'd0);
    end
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) run_case(tv[t]);
    build(0);
    load(1, 48, 7);
    reset_pulse(1);
    load(1, 48, 16);
    repeat (10) @(negedge clk);
    chk("mid_run_busy", {31'b0, bsy[1]}, 32'd1);
    reset_pulse(1);
    run_case(tv[1]);
    run_case(tv[2]);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
